mem_store_buffer: RTL
=====================

Name: mem_store_buffer

Overview:
Sits directly downstream of the load/store lane decoder and upstream of the data memory/MMIO port. It accepts lane-aligned store requests (byte-enable mask plus shifted data) into a posted-write FIFO and drains them to memory in the background. It issues loads to memory with priority over draining, stalling on a read-after-write hazard. The raw 32-bit load word is returned to the decoder for byte/half extraction.

Parameters:
DEPTH, 4, store FIFO entries (power of 2, >=2)
CNT_W, 3, width of sb_count (log2(DEPTH)+1)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request from pipeline
req_ready  output  1  request accepted this cycle when req_valid&req_ready
req_is_load  input  1  1=load, 0=store
req_addr  input  32  byte address; bits [1:0] ignored here
req_wdata  input  32  lane-aligned store data
req_wen  input  4  byte enables for store
rsp_valid  output  1  one-cycle pulse, load data valid
rsp_rdata  output  32  raw memory word for lane extraction
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_we  output  4  byte enables, 0000 for load
mem_req_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_req_wdata  output  32  store data
mem_rsp_valid  input  1  load data returned (>=1 cycle after accept)
mem_rsp_rdata  input  32  load data
sb_count  output  CNT_W  occupied FIFO entries
sb_empty  output  1  sb_count==0

Behaviour:
- Reset (async, rst_n low): FIFO pointers/count = 0; FSM = IDLE; rsp_valid=0, rsp_rdata=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0; sb_empty=1. Reset mid-operation discards pending stores and any in-flight load; a late mem_rsp_valid after reset is ignored.
- Store acceptance: req_ready=1 for stores when count<DEPTH. Accepted entry {addr[31:2], wdata, wen} is written at the tail and visible to drain the next cycle. Store with wen==0000 is accepted and dropped (no enqueue). When full, req_ready=0; there is no same-cycle enqueue into a full FIFO even if dequeue occurs.
- Load acceptance: req_ready=1 for loads only in IDLE and when no valid FIFO entry matches addr[31:2] (hazard). On hazard the load is held (req_ready=0) while draining continues until no match remains.
- FSM states: IDLE, LD_REQ, LD_WAIT, ST_REQ.
  IDLE: accepted load -> LD_REQ (latched addr). Otherwise FIFO non-empty -> ST_REQ. Load accept has priority over starting a drain.
  ST_REQ: mem_req_valid=1 with head entry; on mem_req_ready pop head, -> IDLE.
  LD_REQ: mem_req_valid=1, we=0000; on mem_req_ready -> LD_WAIT.
  LD_WAIT: on mem_rsp_valid, register rsp_rdata, pulse rsp_valid next cycle, -> IDLE.
- Minimum load latency: accept at edge N, mem_req_valid in cycle N+1; with ready=1 and memory returning at N+2, rsp_valid is high in cycle N+3.
- mem_req_* held stable while mem_req_valid && !mem_req_ready.
- Only one outstanding memory transaction. Stores never await a response.
- Pointers wrap modulo DEPTH; count updates as count + push - pop (push and pop in the same cycle keep count unchanged).
- sb_count and sb_empty are registered from count.

Optional Feature:
LOAD_FORWARD_EN: when defined, a load whose youngest matching FIFO entry has wen==1111 is accepted in IDLE without a hazard stall. Its data is returned with rsp_valid in the next cycle, with no memory access. Partial-mask matches still stall. When undefined, every match stalls as described above.

Test Plan:
- Reset with rst_n=0 mid-LD_WAIT -> all outputs 0 immediately, sb_empty=1; stray mem_rsp_valid afterwards gives no rsp_valid.
- 5 stores to 0x100..0x110, mem_req_ready=0 -> first 4 accepted, req_ready=0 on 5th, sb_count=4; release ready -> drained in order with we/data intact, then 5th accepted.
- Store 0x200 wen=0100 data=0x00AB0000, then load 0x202 -> load stalled until the store is issued; the returned word has byte2=0xAB.
- Load 0x300 with memory returning 0xDEADBEEF after 3 cycles -> single rsp_valid pulse, rsp_rdata=0xDEADBEEF, mem_req_we=0000, addr=0x300.
- Store with wen=0000 -> accepted, sb_count unchanged, no memory write.
- LOAD_FORWARD_EN: store 0x400 wen=1111 data=0x12345678, then load 0x400 -> rsp_valid next cycle with 0x12345678 and no mem_req for the load; without the macro, the load stalls until the drain completes.

Source files
------------

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the load/store lane decoder and the data memory/MMIO port.
// Optional store-to-load forwarding of full-word entries is enabled by defining LOAD_FORWARD_EN.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_load,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_wen,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [3:0]       mem_req_we,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_wdata,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_rdata,
  output logic [CNT_W-1:0] sb_count,
  output logic             sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a source holds its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_REQ  = 2'd1,
    LD_WAIT = 2'd2,
    ST_REQ  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [29:0]      fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [3:0]       fifo_wen  [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic [29:0]      ld_addr;
  logic [PTR_W-1:0] scan_idx;
  logic             hazard;
  logic             load_stall;
  logic             load_fwd;
  logic             store_ready;
  logic             load_ready;
  logic             push;
  logic             pop;
  logic             load_acc;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

`ifdef LOAD_FORWARD_EN
  logic        fwd_full;
  logic [31:0] fwd_data;
`endif

  // Scan oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin : scan
    hazard   = 1'b0;
    scan_idx = head;
`ifdef LOAD_FORWARD_EN
    fwd_full = 1'b0;
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (fifo_addr[scan_idx] == req_addr[31:2])) begin
        hazard = 1'b1;
`ifdef LOAD_FORWARD_EN
        fwd_full = (fifo_wen[scan_idx] == 4'hF);
        fwd_data = fifo_data[scan_idx];
`endif
      end
    end
  end

`ifdef LOAD_FORWARD_EN
  assign load_fwd   = hazard && fwd_full;
  assign load_stall = hazard && !fwd_full;
`else
  assign load_fwd   = 1'b0;
  assign load_stall = hazard;
`endif

  assign store_ready = (count < CNT_W'(DEPTH));
  assign load_ready  = (state == IDLE) && !load_stall;
  assign req_ready   = req_is_load ? load_ready : store_ready;

  // A store with an empty byte mask completes the handshake but never occupies an entry.
  assign push     = req_valid && req_ready && !req_is_load && (req_wen != 4'b0000);
  assign load_acc = req_valid && req_ready && req_is_load;
  assign pop      = (state == ST_REQ) && mem_req_ready;

  always_comb begin : count_calc
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin : fsm_next
    state_next = state;
    unique case (state)
      IDLE: begin
        if (load_acc) begin
          state_next = load_fwd ? IDLE : LD_REQ;
        end else if (count != '0) begin
          state_next = ST_REQ;
        end
      end
      LD_REQ: begin
        if (mem_req_ready) state_next = LD_WAIT;
      end
      LD_WAIT: begin
        if (mem_rsp_valid) state_next = IDLE;
      end
      ST_REQ: begin
        if (mem_req_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin : mem_port
    mem_req_valid = 1'b0;
    mem_req_we    = 4'b0000;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (state)
      LD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {ld_addr, 2'b00};
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = fifo_wen[head];
        mem_req_addr  = {fifo_addr[head], 2'b00};
        mem_req_wdata = fifo_data[head];
      end
      default: begin
        mem_req_valid = 1'b0;
      end
    endcase
  end

  // Entry payload needs no reset: it is only observed through the count-qualified pointers.
  always_ff @(posedge clk) begin : fifo_mem
    if (push) begin
      fifo_addr[tail] <= req_addr[31:2];
      fifo_data[tail] <= req_wdata;
      fifo_wen[tail]  <= req_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : fifo_ctrl
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      sb_empty <= 1'b1;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count    <= count_next;
      sb_empty <= (count_next == '0);
    end
  end

  assign sb_count = count;

  always_ff @(posedge clk or negedge rst_n) begin : load_path
    if (!rst_n) begin
      ld_addr   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (load_acc) ld_addr <= req_addr[31:2];
      if ((state == LD_WAIT) && mem_rsp_valid) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem_rsp_rdata;
      end
`ifdef LOAD_FORWARD_EN
      if (load_acc && load_fwd) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= fwd_data;
      end
`endif
    end
  end

endmodule
